// File: rtl/algo_2r1w_b80_pkg.sv
// ---------------------------------------------------------------------------
// algo_2r1w_b80_pkg
// Shared types and constants for the 2r1w_b80 T1 bank responder.
//   t1_state_e     : bank FSM state (INIT clears the array, IDLE serves it)
//   MAX_SRAM_DELAY : largest supported read latency of the delay pipe
// ---------------------------------------------------------------------------
package algo_2r1w_b80_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } t1_state_e;

    localparam int MAX_SRAM_DELAY = 8;

endpackage

// File: rtl/algo_2r1w_b80_dly_pipe.sv
// ---------------------------------------------------------------------------
// algo_2r1w_b80_dly_pipe
// Read-latency shift pipe carrying data plus a valid bit. Each stage only
// loads new data when the incoming valid is set, so the output data holds
// the last delivered read while out_vld is low.
// Ports:
//   clk, rst   : clock, asynchronous active-low clear of every stage
//   in_vld     : a read sample enters the pipe this cycle
//   in_data    : the read sample
//   out_vld    : in_vld delayed by SRAM_DELAY cycles
//   out_data   : in_data delayed by SRAM_DELAY cycles, held between reads
// ---------------------------------------------------------------------------
module algo_2r1w_b80_dly_pipe
    import algo_2r1w_b80_pkg::*;
#(
    parameter int PHYWDTH    = 128,
    parameter int SRAM_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic [PHYWDTH-1:0] in_data,
    output logic               out_vld,
    output logic [PHYWDTH-1:0] out_data
);

    // Latencies outside 1..MAX_SRAM_DELAY are clamped into the legal range.
    localparam int PIPE_DEPTH = (SRAM_DELAY < 1) ? 1 :
                                (SRAM_DELAY > MAX_SRAM_DELAY) ? MAX_SRAM_DELAY :
                                SRAM_DELAY;

    logic [PHYWDTH-1:0]  data_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_vld  = vld_q[PIPE_DEPTH-1];
    assign out_data = data_q[PIPE_DEPTH-1];

endmodule

// File: rtl/algo_2r1w_b80_t1_bank.sv
// ---------------------------------------------------------------------------
// algo_2r1w_b80_t1_bank
// Behavioural responder for one physical T1 bank of the 2r1w_b80 algorithm
// memory. After reset it clears every row (INIT), then serves one bit-masked
// write and one read per cycle (IDLE). Reads return data SRAM_DELAY cycles
// later; protocol violations are reported as registered one-cycle pulses.
//
// Handshake: writeA and readB are single-cycle strobes with no backpressure.
// An access is honoured only in a cycle where init_done is high; doutB_vld
// is a one-cycle qualifier for doutB, which holds its value otherwise.
//
// Ports:
//   clk, rst        : clock, async-assert active-low reset
//   writeA/addrA    : write strobe and row
//   dinA/bwA        : write data and per-bit write enable (1 = write bit)
//   readB/addrB     : read strobe and row
//   doutB/doutB_vld : read data and its valid
//   init_done       : array clear finished, accesses are served
//   err_coll        : same-row write and read in one cycle
//   err_range       : an address was >= NUMSROW
//   err_busy        : a strobe arrived before init_done
//   dbg_state       : current FSM state
// ---------------------------------------------------------------------------
module algo_2r1w_b80_t1_bank
    import algo_2r1w_b80_pkg::*;
#(
    parameter int PHYWDTH    = 128,
    parameter int NUMSROW    = 4096,
    parameter int BITSROW    = 12,
    parameter int SRAM_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               writeA,
    input  logic [BITSROW-1:0] addrA,
    input  logic [PHYWDTH-1:0] dinA,
    input  logic [PHYWDTH-1:0] bwA,
    input  logic               readB,
    input  logic [BITSROW-1:0] addrB,
    output logic [PHYWDTH-1:0] doutB,
    output logic               doutB_vld,
    output logic               init_done,
    output logic               err_coll,
    output logic               err_range,
    output logic               err_busy,
    output t1_state_e          dbg_state
);

    // One extra bit so the compare and the clear counter work when
    // NUMSROW == 2**BITSROW.
    localparam logic [BITSROW:0] ROW_LIMIT = (BITSROW+1)'(NUMSROW);
    localparam logic [BITSROW:0] LAST_ROW  = (BITSROW+1)'(NUMSROW - 1);

    t1_state_e          state;
    logic [BITSROW:0]   clr_cnt;
    logic [PHYWDTH-1:0] mem [NUMSROW];

    logic               in_idle;
    logic               wr_in_range;
    logic               rd_in_range;
    logic               wr_do;
    logic               rd_do;
    logic [PHYWDTH-1:0] rd_data;

    assign in_idle     = (state == IDLE);
    assign wr_in_range = ({1'b0, addrA} < ROW_LIMIT);
    assign rd_in_range = ({1'b0, addrB} < ROW_LIMIT);
    assign wr_do       = in_idle & writeA & wr_in_range;
    // Out-of-range reads still produce a valid response, carrying zero.
    assign rd_do       = in_idle & readB;
    // Sampled combinationally before the edge, so a same-row write in this
    // cycle is not visible until the next read.
    assign rd_data     = rd_in_range ? mem[addrB] : '0;

    // FSM, clear counter and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
            err_coll  <= 1'b0;
            err_range <= 1'b0;
            err_busy  <= 1'b0;
        end else begin
            err_busy  <= (state == INIT) & (writeA | readB);
            err_range <= in_idle & ((writeA & ~wr_in_range) | (readB & ~rd_in_range));
            err_coll  <= in_idle & writeA & readB & wr_in_range & rd_in_range
                         & (addrA == addrB);
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ROW) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    // Only reset leaves IDLE.
                    state <= IDLE;
                end
                default: begin
                    state     <= INIT;
                    clr_cnt   <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset of its own; INIT overwrites every row with zero.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_cnt[BITSROW-1:0]] <= '0;
        end else if (wr_do) begin
            mem[addrA] <= (mem[addrA] & ~bwA) | (dinA & bwA);
        end
    end

    algo_2r1w_b80_dly_pipe #(
        .PHYWDTH    (PHYWDTH),
        .SRAM_DELAY (SRAM_DELAY)
    ) u_dly_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_do),
        .in_data  (rd_data),
        .out_vld  (doutB_vld),
        .out_data (doutB)
    );

    assign dbg_state = state;

endmodule

// File: tb/tb_algo_2r1w_b80_t1_bank.sv
// ---------------------------------------------------------------------------
// tb_algo_2r1w_b80_t1_bank
// Cycle-stepped bench: every cycle the reference model updates from the
// inputs sampled at the rising edge, and all outputs are compared on the
// falling edge. Read responses are tracked in an expected queue with due
// cycles; the array model is a plain array cleared whenever reset is seen.
// ---------------------------------------------------------------------------
module tb_algo_2r1w_b80_t1_bank;
    import algo_2r1w_b80_pkg::*;

    localparam int W  = 64;
    localparam int N  = 16;
    localparam int AW = 5;
    localparam int D  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          writeA = 1'b0;
    logic [AW-1:0] addrA  = '0;
    logic [W-1:0]  dinA   = '0;
    logic [W-1:0]  bwA    = '0;
    logic          readB  = 1'b0;
    logic [AW-1:0] addrB  = '0;
    logic [W-1:0]  doutB;
    logic          doutB_vld;
    logic          init_done;
    logic          err_coll;
    logic          err_range;
    logic          err_busy;
    t1_state_e     dbg_state;

    algo_2r1w_b80_t1_bank #(
        .PHYWDTH    (W),
        .NUMSROW    (N),
        .BITSROW    (AW),
        .SRAM_DELAY (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .writeA    (writeA),
        .addrA     (addrA),
        .dinA      (dinA),
        .bwA       (bwA),
        .readB     (readB),
        .addrB     (addrB),
        .doutB     (doutB),
        .doutB_vld (doutB_vld),
        .init_done (init_done),
        .err_coll  (err_coll),
        .err_range (err_range),
        .err_busy  (err_busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] model_mem [N];
    logic [W-1:0] exp_q [$];
    int           due_q [$];
    int           edge_cnt = 0;
    int           rel_cyc  = 0;
    logic [W-1:0] last_dout = '0;
    logic         exp_coll  = 1'b0;
    logic         exp_range = 1'b0;
    logic         exp_busy  = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rel_cyc   = 0;
        last_dout = '0;
        exp_q.delete();
        due_q.delete();
        for (int i = 0; i < N; i++) begin
            model_mem[i] = '0;
        end
    endtask

    // Applies the spec rules to the inputs sampled at this rising edge.
    task automatic model_edge();
        bit wr_ok;
        bit rd_ok;
        exp_coll  = 1'b0;
        exp_range = 1'b0;
        exp_busy  = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (rel_cyc < N) begin
            exp_busy = writeA | readB;
        end else begin
            wr_ok = int'(addrA) < N;
            rd_ok = int'(addrB) < N;
            if (readB) begin
                exp_q.push_back(rd_ok ? model_mem[addrB] : '0);
                due_q.push_back(edge_cnt + D - 1);
            end
            exp_range = (writeA & ~wr_ok) | (readB & ~rd_ok);
            exp_coll  = writeA & readB & wr_ok & rd_ok & (addrA == addrB);
            if (writeA && wr_ok) begin
                model_mem[addrA] = (model_mem[addrA] & ~bwA) | (dinA & bwA);
            end
        end
        rel_cyc++;
    endtask

    task automatic check_outputs();
        logic         exp_vld;
        logic [W-1:0] exp_data;
        exp_vld  = 1'b0;
        exp_data = last_dout;
        if (due_q.size() > 0 && due_q[0] == edge_cnt) begin
            exp_vld   = 1'b1;
            exp_data  = exp_q.pop_front();
            void'(due_q.pop_front());
            last_dout = exp_data;
        end
        check("doutB_vld", W'(doutB_vld), W'(exp_vld));
        check("doutB",     doutB,         exp_data);
        check("init_done", W'(init_done), W'(rel_cyc >= N));
        check("err_coll",  W'(err_coll),  W'(exp_coll));
        check("err_range", W'(err_range), W'(exp_range));
        check("err_busy",  W'(err_busy),  W'(exp_busy));
        check("state",     W'(dbg_state), W'((rel_cyc >= N) ? IDLE : INIT));
    endtask

    // ---------------- driver tasks ----------------
    // Called on a falling edge: drive, take one rising edge, check at the
    // next falling edge, then return the strobes to idle.
    task automatic cycle(input logic wa, input logic [AW-1:0] aa, input logic [W-1:0] da,
                         input logic [W-1:0] ba, input logic rb, input logic [AW-1:0] ab);
        writeA = wa; addrA = aa; dinA = da; bwA = ba;
        readB  = rb; addrB = ab;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        edge_cnt++;
        writeA = 1'b0; readB = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, '0, '0, '0, 1'b0, '0);
        end
    endtask

    task automatic wr(input int row, input logic [W-1:0] data, input logic [W-1:0] mask);
        cycle(1'b1, AW'(row), data, mask, 1'b0, '0);
    endtask

    task automatic rd(input int row);
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(row));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk);
        nop(3);                       // held in reset
        rst = 1'b1;                   // release on a falling edge
        nop(2);                       // init cycles 0, 1
        rd(0);                        // init cycle 2: busy, no response
        nop(N - 3);                   // finish clear, init_done now high
        rd(5);                        // cleared row reads 0
        nop(D);

        wr(3, '1, 64'h0000_0000_0000_00FF);
        rd(3);                        // low byte only
        nop(D);

        cycle(1'b1, AW'(7), 64'hA5, '1, 1'b1, AW'(7));   // collision, old data
        rd(7);                        // new data 0xA5
        nop(D);

        cycle(1'b1, AW'(N), '1, '1, 1'b1, AW'(N + 1));   // both out of range
        rd(N - 1);                    // unchanged last row
        nop(D);

        for (int i = 0; i < 10; i++) begin
            wr(i, {32'hC0DE_0000 + 32'(i), $urandom}, '1);
        end
        for (int i = 0; i < 10; i++) begin
            rd(i);                    // back-to-back pipelined reads
        end
        nop(D);

        for (int i = 0; i < 200; i++) begin
            cycle(1'(($urandom_range(0, 2) == 0) ? 0 : 1), AW'($urandom_range(0, N + 1)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, N + 1)));
        end
        nop(D);

        // Reset in the middle of a read burst.
        for (int i = 0; i < 6; i++) begin
            rd(i);
        end
        check("vld_before_reset", W'(doutB_vld), W'(1'b1));
        rst = 1'b0;
        #1;
        check("vld_async_reset",  W'(doutB_vld), '0);
        check("dout_async_reset", doutB,         '0);
        check("init_async_reset", W'(init_done), '0);
        model_reset();
        @(negedge clk);
        edge_cnt++;
        nop(2);
        rst = 1'b1;
        rd(2);                        // init cycle 0 again: busy
        nop(N - 1);
        rd(3);                        // row rewritten to zero by the clear
        rd(0);
        nop(D + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
